// File: rtl/multiword_add_sequencer_pkg.sv
// Shared word width and FSM state type for the multiword add sequencer.
package multiword_add_sequencer_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/multiword_add_sequencer.sv
// Sequences a wide add/subtract through an external 16-bit adder, one word per
// clock, LSW first, chaining the adder carry-out into the next word's carry-in.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [WORD_W*WORDS-1:0]  A,
    input  logic [WORD_W*WORDS-1:0]  B,
    input  logic                     CinIn,
    input  logic                     Sub,
    output logic [WORD_W-1:0]        AddX,
    output logic [WORD_W-1:0]        AddY,
    output logic                     AddCin,
    input  logic [WORD_W-1:0]        AddS,
    input  logic                     AddCout,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [WORD_W*WORDS-1:0]  Result,
    output logic                     Cout,
    output logic                     Overflow,
    output logic                     Zero
);

    localparam int OP_W = WORD_W * WORDS;
    localparam int K_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q;
    logic              carry_q;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   beff_q;
    logic [OP_W-1:0]   result_d;
    logic              accept;
    logic              running;
    logic              last_word;

    assign InReady   = (state_q == ST_IDLE);
    assign OutValid  = (state_q == ST_DONE);
    assign running   = (state_q == ST_RUN);
    assign accept    = InValid & InReady;
    assign last_word = running & (k_q == K_LAST);

    // Word-slice muxes feeding the external adder; parked at zero outside RUN.
    assign AddX   = running ? a_q[int'(k_q)*WORD_W +: WORD_W]    : '0;
    assign AddY   = running ? beff_q[int'(k_q)*WORD_W +: WORD_W] : '0;
    assign AddCin = running ? carry_q : 1'b0;

    always_comb begin
        result_d = Result;
        result_d[int'(k_q)*WORD_W +: WORD_W] = AddS;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)             state_d = ST_RUN;
            ST_RUN:  if (k_q == K_LAST)      state_d = ST_DONE;
            ST_DONE: if (OutReady)           state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word counter, running carry and registered result/flags.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            k_q      <= '0;
            carry_q  <= 1'b0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
        end else if (accept) begin
            k_q     <= '0;
            carry_q <= Sub | CinIn;
        end else if (running) begin
            Result  <= result_d;
            carry_q <= AddCout;
            k_q     <= k_q + 1'b1;
            if (last_word) begin
                Cout     <= AddCout;
                Overflow <= (a_q[OP_W-1] == beff_q[OP_W-1]) &
                            (result_d[OP_W-1] != a_q[OP_W-1]);
                Zero     <= (result_d == '0);
            end
        end
    end

    // Operand capture is pure data; the FSM keeps it off the adder outside RUN.
    always_ff @(posedge Clk) begin
        if (accept) begin
            a_q    <= A;
            beff_q <= Sub ? ~B : B;
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORDS=4) with a behavioural 16-bit adder.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int OP_W  = 16 * WORDS;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              InValid;
    logic              InReady;
    logic [OP_W-1:0]   A;
    logic [OP_W-1:0]   B;
    logic              CinIn;
    logic              Sub;
    logic [15:0]       AddX;
    logic [15:0]       AddY;
    logic              AddCin;
    logic [15:0]       AddS;
    logic              AddCout;
    logic              OutValid;
    logic              OutReady;
    logic [OP_W-1:0]   Result;
    logic              Cout;
    logic              Overflow;
    logic              Zero;
    logic [16:0]       add_sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    assign add_sum = {1'b0, AddX} + {1'b0, AddY} + {16'd0, AddCin};
    assign AddS    = add_sum[15:0];
    assign AddCout = add_sum[16];

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .CinIn(CinIn), .Sub(Sub),
        .AddX(AddX), .AddY(AddY), .AddCin(AddCin),
        .AddS(AddS), .AddCout(AddCout),
        .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Cout(Cout), .Overflow(Overflow), .Zero(Zero)
    );

    typedef struct {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            cin;
        logic            sub;
        logic [OP_W-1:0] res;
        logic            cout;
        logic            ovf;
        logic            zero;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: whole-operand arithmetic; signed overflow from a wider signed sum.
    function automatic void model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [OP_W-1:0] r, output logic co,
                                  output logic ov, output logic z);
        logic [OP_W:0]          u;
        logic signed [OP_W+1:0] s;
        logic signed [OP_W+1:0] sa;
        logic signed [OP_W+1:0] sb;
        sa = $signed({{2{a[OP_W-1]}}, a});
        sb = $signed({{2{b[OP_W-1]}}, b});
        if (sub) begin
            r  = a - b;
            co = (a >= b);
            s  = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin};
            r  = u[OP_W-1:0];
            co = u[OP_W];
            s  = sa + sb + $signed({{(OP_W+1){1'b0}}, cin});
        end
        ov = (s[OP_W] != s[OP_W-1]);
        z  = (r == '0);
    endfunction

    // Issues one operation from IDLE, waits for the result, holds OutReady low
    // for `stall` cycles, samples outputs and completes the result handshake.
    task automatic exec_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                           input logic cin, input logic sub, input int stall,
                           output logic [OP_W-1:0] r, output logic co,
                           output logic ov, output logic z, output int lat);
        A = a; B = b; CinIn = cin; Sub = sub; InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 50) begin
            @(posedge Clk); #1;
            lat++;
        end
        repeat (stall) begin
            @(posedge Clk); #1;
        end
        r = Result; co = Cout; ov = Overflow; z = Zero;
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
    endtask

    initial begin
        logic [OP_W-1:0] r, er, na;
        logic            co, ov, z, ec, eo, ez;
        int              lat;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{64'h1234, 64'h1, 1'b1, 1'b0, 64'h1236, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{64'h9, 64'h9, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};

        Rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        A = '0; B = '0; CinIn = 1'b0; Sub = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_inready",  InReady,  1);
        check("rst_outvalid", OutValid, 0);
        check("rst_result",   Result,   0);
        check("rst_flags",    {Cout, Overflow, Zero}, 0);
        check("rst_addxy",    {AddX, AddY, 15'd0, AddCin}, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            exec_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, r, co, ov, z, lat);
            check($sformatf("tab%0d_latency", i), 64'(lat), WORDS);
            check($sformatf("tab%0d_result", i), r, vecs[i].res);
            check($sformatf("tab%0d_cout", i), co, vecs[i].cout);
            check($sformatf("tab%0d_ovf", i), ov, vecs[i].ovf);
            check($sformatf("tab%0d_zero", i), z, vecs[i].zero);
        end

        // Stall in DONE: outputs hold, operands offered meanwhile are ignored
        model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0, er, ec, eo, ez);
        A = 64'h0123_4567_89AB_CDEF; B = 64'h1111_2222_3333_4444; CinIn = 1'b0; Sub = 1'b0;
        InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 50) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("stall_latency", 64'(lat), WORDS);
        for (int i = 0; i < 10; i++) begin
            A = {$urandom, $urandom}; B = {$urandom, $urandom}; InValid = 1'b1;
            @(posedge Clk); #1;
            check("stall_outvalid", OutValid, 1);
            check("stall_inready",  InReady,  0);
            check("stall_result",   Result,   er);
        end
        check("stall_cout", Cout, ec);
        InValid = 1'b0; OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
        check("post_hs_outvalid", OutValid, 0);
        check("post_hs_inready",  InReady,  1);
        check("idle_addxy", {AddX, AddY, 15'd0, AddCin}, 0);
        check("idle_result_kept", Result, er);
        exec_op(64'h2, 64'h3, 1'b0, 1'b0, 0, r, co, ov, z, lat);
        check("after_stall_latency", 64'(lat), WORDS);
        check("after_stall_result", r, 64'h5);

        // Reset asserted in the second RUN cycle
        A = 64'hDEAD_BEEF_CAFE_F00D; B = 64'h1357_9BDF_0246_8ACE; CinIn = 1'b1; Sub = 1'b0;
        InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        check("midrst_result",   Result,   0);
        check("midrst_flags",    {Cout, Overflow, Zero}, 0);
        check("midrst_outvalid", OutValid, 0);
        check("midrst_inready",  InReady,  1);
        check("midrst_addxy",    {AddX, AddY, 15'd0, AddCin}, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        exec_op(64'h1, 64'h1, 1'b0, 1'b0, 0, r, co, ov, z, lat);
        check("postrst_latency", 64'(lat), WORDS);
        check("postrst_result", r, 64'h2);
        check("postrst_flags", {co, ov, z}, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [OP_W-1:0] ra, rb;
            logic rc, rs;
            ra = {$urandom, $urandom};
            rb = (i % 8 == 3) ? ra : {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rc, rs, er, ec, eo, ez);
            exec_op(ra, rb, rc, rs, $urandom_range(0, 2), r, co, ov, z, lat);
            check($sformatf("rnd%0d_latency", i), 64'(lat), WORDS);
            check($sformatf("rnd%0d_result", i), r, er);
            check($sformatf("rnd%0d_cout", i), co, ec);
            check($sformatf("rnd%0d_ovf", i), ov, eo);
            check($sformatf("rnd%0d_zero", i), z, ez);
        end

        na = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + int'(na[0]));
        $finish;
    end

endmodule
